// File: rtl/rx_selio_word_align_pkg.sv
// -----------------------------------------------------------------------------
// rx_selio_word_align_pkg
// Shared types and defaults for the rx_selio word aligner and its capture FIFO.
//   align_state_e      : aligner FSM state encoding
//   DEF_*              : default parameter values for the aligner and FIFO
//   cnt_width()        : bits needed to hold a count from 0 up to max_val
// -----------------------------------------------------------------------------
package rx_selio_word_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_e;

    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam logic [7:0]  DEF_TRAIN_PATTERN = 8'h5C;
    localparam int unsigned DEF_MATCH_COUNT   = 16;
    localparam int unsigned DEF_SLIP_WAIT     = 4;
    localparam int unsigned DEF_MAX_SLIPS     = 15;
    localparam int unsigned DEF_FIFO_DEPTH    = 16;

    // Width of a counter that must reach max_val inclusive (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_selio_sync_fifo.sv
// -----------------------------------------------------------------------------
// rx_selio_sync_fifo
// Single-clock capture FIFO with a registered head word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of all contents (wins over push/pop)
//   push, din   : write request and word
//   ready       : consumer accepts the head word (pop when dout_valid)
//   dout        : head word, registered
//   dout_valid  : head word valid, registered
//   level       : words held (saturates at FIFO_DEPTH)
//   full        : level == FIFO_DEPTH
// A word pushed in cycle N is visible on dout in cycle N+1. When full, a
// push is only accepted if a pop frees a slot in the same cycle.
// -----------------------------------------------------------------------------
module rx_selio_sync_fifo
    import rx_selio_word_align_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                din,
    input  logic                                 ready,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic                                 dout_valid,
    output logic [cnt_width(FIFO_DEPTH)-1:0]     level,
    output logic                                 full
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = cnt_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic [DATA_WIDTH-1:0] head_r;
    logic                  head_valid_r;

    logic                  pop_s;
    logic                  full_s;
    logic                  push_ok_s;
    logic [PW-1:0]         rd_ptr_next_s;
    logic [LW-1:0]         level_after_pop_s;
    logic [LW-1:0]         level_next_s;
    logic [DATA_WIDTH-1:0] head_next_s;

    // Next-state computation for pointers, level and the registered head word.
    always_comb begin
        pop_s             = ready && head_valid_r;
        full_s            = (level_r == LW'(FIFO_DEPTH));
        push_ok_s         = push && (!full_s || pop_s);
        rd_ptr_next_s     = rd_ptr_r + PW'(pop_s);
        level_after_pop_s = level_r - LW'(pop_s);
        level_next_s      = level_after_pop_s + LW'(push_ok_s);
        // With nothing left behind the popped word the new head can only be
        // the incoming word; otherwise it is already sitting in storage.
        if (level_after_pop_s == '0) begin
            if (push_ok_s) begin
                head_next_s = din;
            end else begin
                head_next_s = head_r;
            end
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer, level and head-register update with flush priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            head_r       <= '0;
            head_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            rd_ptr_r     <= rd_ptr_next_s;
            level_r      <= level_next_s;
            head_r       <= head_next_s;
            head_valid_r <= (level_next_s != '0);
        end
    end

    assign dout       = head_r;
    assign dout_valid = head_valid_r;
    assign level      = level_r;
    assign full       = full_s;

endmodule

// File: rtl/rx_selio_word_align.sv
// -----------------------------------------------------------------------------
// rx_selio_word_align
// Finds word alignment on the ISERDES output by pulsing bitslip until the
// training word is seen MATCH_COUNT times in a row, then captures every
// received word into a FIFO drained by the register slave.
//   S_AXI_ACLK, S_AXI_ARESETN : clock (= ISERDES CLKDIV), async active-low reset
//   align_start               : pulse, restart hunt, flush FIFO, clear sticky flags
//   serdes_data, serdes_valid : deserialized word and its qualifier
//   bitslip                   : one-cycle pulse to ISERDES BITSLIP
//   locked                    : alignment achieved, capture active
//   align_fail                : sticky, all slips used without lock
//   slip_count                : bitslips issued in the current hunt
//   overflow                  : sticky, a captured word was dropped (FIFO full)
//   fifo_level                : words held in the FIFO
//   m_data, m_valid, m_ready  : FIFO head handshake
// -----------------------------------------------------------------------------
module rx_selio_word_align
    import rx_selio_word_align_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(DEF_TRAIN_PATTERN),
    parameter int unsigned           MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int unsigned           SLIP_WAIT     = DEF_SLIP_WAIT,
    parameter int unsigned           MAX_SLIPS     = DEF_MAX_SLIPS,
    parameter int unsigned           FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESETN,
    input  logic                             align_start,
    input  logic [DATA_WIDTH-1:0]            serdes_data,
    input  logic                             serdes_valid,
    output logic                             bitslip,
    output logic                             locked,
    output logic                             align_fail,
    output logic [3:0]                       slip_count,
    output logic                             overflow,
    output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    input  logic                             m_ready
);

    localparam int unsigned MC_W = cnt_width(MATCH_COUNT);
    localparam int unsigned SW_W = cnt_width(SLIP_WAIT);

    align_state_e    state_r;
    logic [MC_W-1:0] match_cnt_r;
    logic [SW_W-1:0] settle_cnt_r;
    logic [3:0]      slip_count_r;
    logic            bitslip_r;
    logic            locked_r;
    logic            align_fail_r;
    logic            overflow_r;

    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            fifo_full_s;

    // Capture control: a restart pulse flushes, so it also suppresses the push.
    always_comb begin
        push_s = (state_r == ST_LOCKED) && serdes_valid && !align_start;
        pop_s  = m_valid && m_ready;
        drop_s = push_s && fifo_full_s && !pop_s;
    end

    // Alignment FSM with its counters and registered status outputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r      <= ST_IDLE;
            match_cnt_r  <= '0;
            settle_cnt_r <= '0;
            slip_count_r <= 4'd0;
            bitslip_r    <= 1'b0;
            locked_r     <= 1'b0;
            align_fail_r <= 1'b0;
        end else if (align_start) begin
            state_r      <= ST_CHECK;
            match_cnt_r  <= '0;
            settle_cnt_r <= '0;
            slip_count_r <= 4'd0;
            bitslip_r    <= 1'b0;
            locked_r     <= 1'b0;
            align_fail_r <= 1'b0;
        end else begin
            // Default low so the pulse can never outlive the SLIP state.
            bitslip_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_CHECK: begin
                    if (serdes_valid) begin
                        if (serdes_data == TRAIN_PATTERN) begin
                            if (match_cnt_r == MC_W'(MATCH_COUNT - 1)) begin
                                state_r     <= ST_LOCKED;
                                locked_r    <= 1'b1;
                                match_cnt_r <= '0;
                            end else begin
                                match_cnt_r <= match_cnt_r + MC_W'(1'b1);
                            end
                        end else if (slip_count_r == 4'(MAX_SLIPS)) begin
                            state_r      <= ST_FAIL;
                            align_fail_r <= 1'b1;
                            match_cnt_r  <= '0;
                        end else begin
                            // Raised on entry so the pulse coincides with SLIP.
                            state_r     <= ST_SLIP;
                            bitslip_r   <= 1'b1;
                            match_cnt_r <= '0;
                        end
                    end
                end
                ST_SLIP: begin
                    state_r      <= ST_SETTLE;
                    slip_count_r <= slip_count_r + 4'd1;
                    settle_cnt_r <= '0;
                end
                ST_SETTLE: begin
                    // Words still shifting inside the ISERDES are thrown away.
                    if (serdes_valid) begin
                        if (settle_cnt_r == SW_W'(SLIP_WAIT - 1)) begin
                            state_r      <= ST_CHECK;
                            match_cnt_r  <= '0;
                            settle_cnt_r <= '0;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + SW_W'(1'b1);
                        end
                    end
                end
                ST_LOCKED: begin
                    state_r <= ST_LOCKED;
                end
                ST_FAIL: begin
                    state_r <= ST_FAIL;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    match_cnt_r  <= '0;
                    settle_cnt_r <= '0;
                    slip_count_r <= 4'd0;
                    locked_r     <= 1'b0;
                    align_fail_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag, cleared only by a restart.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            overflow_r <= 1'b0;
        end else if (align_start) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    rx_selio_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .flush      (align_start),
        .push       (push_s),
        .din        (serdes_data),
        .ready      (m_ready),
        .dout       (m_data),
        .dout_valid (m_valid),
        .level      (fifo_level),
        .full       (fifo_full_s)
    );

    assign bitslip    = bitslip_r;
    assign locked     = locked_r;
    assign align_fail = align_fail_r;
    assign slip_count = slip_count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_rx_selio_word_align.sv
// -----------------------------------------------------------------------------
// tb_rx_selio_word_align
// Scoreboard bench: captured words are queued as expected FIFO contents when
// driven and compared when the DUT pops them. A small ISERDES model rotates
// the training word by one bit per bitslip pulse.
// -----------------------------------------------------------------------------
module tb_rx_selio_word_align;

    logic       tb_ACLK = 1'b0;
    logic       tb_ARESETN = 1'b0;
    logic       align_start = 1'b0;
    logic [7:0] serdes_data = 8'h00;
    logic       serdes_valid = 1'b0;
    logic       bitslip;
    logic       locked;
    logic       align_fail;
    logic [3:0] slip_count;
    logic       overflow;
    logic [4:0] fifo_level;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       cap_en = 1'b0;
    logic [7:0] base_word = 8'h5C;
    int         rot = 0;
    int         cyc = 0;
    int         slips = 0;
    int         last_slip = 0;
    int         n;

    always #5 tb_ACLK = ~tb_ACLK;

    rx_selio_word_align dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (tb_ARESETN),
        .align_start   (align_start),
        .serdes_data   (serdes_data),
        .serdes_valid  (serdes_valid),
        .bitslip       (bitslip),
        .locked        (locked),
        .align_fail    (align_fail),
        .slip_count    (slip_count),
        .overflow      (overflow),
        .fifo_level    (fifo_level),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int r);
        logic [15:0] d;
        d = {v, v} << (r % 8);
        return d[15:8];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: update the model for the coming edge, then check after it.
    task automatic tick();
        logic pop;
        check_val("m_valid", {31'd0, m_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        pop = m_ready && (exp_q.size() != 0);
        if (pop) check_val("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
        if (align_start) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (cap_en && serdes_valid) begin
                if (exp_q.size() < 16) exp_q.push_back(serdes_data);
                else exp_ovf = 1'b1;
            end
        end
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        cyc++;
        check_val("fifo_level", {27'd0, fifo_level}, exp_q.size());
        check_val("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        if (bitslip) begin
            if (slips > 0) check_val("slip_gap_ge5", (cyc - last_slip >= 5) ? 32'd1 : 32'd0, 32'd1);
            slips++;
            last_slip = cyc;
            rot = (rot + 7) % 8;
            serdes_data = rotl8(base_word, rot);
        end
    endtask

    task automatic hunt(input logic [7:0] base, input int r, input int bound, output int cycles);
        base_word    = base;
        rot          = r;
        serdes_data  = rotl8(base_word, rot);
        serdes_valid = 1'b1;
        slips        = 0;
        align_start  = 1'b1;
        tick();
        align_start  = 1'b0;
        cycles = 0;
        while (!locked && !align_fail && cycles < bound) begin
            tick();
            cycles++;
        end
        serdes_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_bitslip"},    {31'd0, bitslip},    32'd0);
        check_val({pfx, "_locked"},     {31'd0, locked},     32'd0);
        check_val({pfx, "_align_fail"}, {31'd0, align_fail}, 32'd0);
        check_val({pfx, "_slip_count"}, {28'd0, slip_count}, 32'd0);
        check_val({pfx, "_overflow"},   {31'd0, overflow},   32'd0);
        check_val({pfx, "_fifo_level"}, {27'd0, fifo_level}, 32'd0);
        check_val({pfx, "_m_valid"},    {31'd0, m_valid},    32'd0);
        check_val({pfx, "_m_data"},     {24'd0, m_data},     32'd0);
    endtask

    // Assert reset between edges, check outputs immediately, then release.
    task automatic do_reset(input string pfx);
        tb_ARESETN = 1'b0;
        #1;
        check_reset_vals(pfx);
        exp_q.delete();
        exp_ovf = 1'b0;
        cap_en  = 1'b0;
        @(negedge tb_ACLK);
        @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
    endtask

    initial begin
        @(negedge tb_ACLK);
        do_reset("rst0");

        // Aligned stream: lock after exactly 16 matches, no slips.
        hunt(8'h5C, 0, 200, n);
        check_val("t1_lock_cycles", n, 32'd16);
        check_val("t1_locked", {31'd0, locked}, 32'd1);
        check_val("t1_slips", slips, 32'd0);
        check_val("t1_slip_count", {28'd0, slip_count}, 32'd0);

        // Stream rotated by 3 bits (8'hE2): three slips then lock.
        hunt(8'h5C, 3, 500, n);
        check_val("t2_locked", {31'd0, locked}, 32'd1);
        check_val("t2_slips", slips, 32'd3);
        check_val("t2_slip_count", {28'd0, slip_count}, 32'd3);

        // Pattern absent: 15 slips then sticky failure.
        hunt(8'h00, 0, 500, n);
        check_val("t3_align_fail", {31'd0, align_fail}, 32'd1);
        check_val("t3_locked", {31'd0, locked}, 32'd0);
        check_val("t3_slips", slips, 32'd15);
        check_val("t3_slip_count", {28'd0, slip_count}, 32'd15);
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        check_val("t3_fail_cleared", {31'd0, align_fail}, 32'd0);
        check_val("t3_count_cleared", {28'd0, slip_count}, 32'd0);

        // Lock again for capture tests.
        hunt(8'h5C, 0, 200, n);
        check_val("t4_locked", {31'd0, locked}, 32'd1);
        cap_en = 1'b1;

        // Fill to full, then push and pop together.
        m_ready = 1'b0;
        serdes_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serdes_data = 8'h21 + 8'(i);
            tick();
        end
        serdes_data = 8'h31;
        m_ready = 1'b1;
        tick();
        check_val("t5_level_pushpop", {27'd0, fifo_level}, 32'd16);
        check_val("t5_no_overflow", {31'd0, overflow}, 32'd0);
        serdes_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check_val("t5_drained", {31'd0, m_valid}, 32'd0);

        // Empty with push and ready: word accepted, not popped.
        serdes_valid = 1'b1;
        serdes_data = 8'h40;
        tick();
        check_val("t5_empty_pushpop_level", {27'd0, fifo_level}, 32'd1);
        serdes_valid = 1'b0;
        tick();

        // 17 pushes with no consumer: 16 kept, one dropped, overflow sticky.
        m_ready = 1'b0;
        serdes_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            serdes_data = 8'(i);
            tick();
        end
        serdes_valid = 1'b0;
        check_val("t4_level_full", {27'd0, fifo_level}, 32'd16);
        check_val("t4_overflow", {31'd0, overflow}, 32'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check_val("t4_drained", {27'd0, fifo_level}, 32'd0);

        // Restart coincident with a push: flush wins, no overflow.
        m_ready = 1'b0;
        serdes_valid = 1'b1;
        serdes_data = 8'h61;
        tick();
        serdes_data = 8'h62;
        tick();
        serdes_data = 8'h63;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        serdes_valid = 1'b0;
        cap_en = 1'b0;
        check_val("t7_flush_level", {27'd0, fifo_level}, 32'd0);
        check_val("t7_flush_ovf", {31'd0, overflow}, 32'd0);
        check_val("t7_flush_unlocked", {31'd0, locked}, 32'd0);

        // Reset in the middle of SETTLE.
        base_word = 8'h5C;
        rot = 3;
        serdes_data = rotl8(base_word, rot);
        serdes_valid = 1'b1;
        slips = 0;
        align_start = 1'b1;
        tick();
        align_start = 1'b0;
        n = 0;
        while (slips == 0 && n < 50) begin
            tick();
            n++;
        end
        check_val("t6_first_slip", slips, 32'd1);
        tick();
        tick();
        do_reset("t6_settle");
        slips = 0;
        for (int i = 0; i < 20; i++) tick();
        check_val("t6_idle_no_slip", slips, 32'd0);
        check_val("t6_idle_unlocked", {31'd0, locked}, 32'd0);

        // Reset in the middle of capture.
        hunt(8'h5C, 0, 200, n);
        check_val("t8_locked", {31'd0, locked}, 32'd1);
        cap_en = 1'b1;
        m_ready = 1'b0;
        serdes_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serdes_data = 8'hA0 + 8'(i);
            tick();
        end
        check_val("t8_level_before", {27'd0, fifo_level}, 32'd3);
        do_reset("t8_capture");
        slips = 0;
        for (int i = 0; i < 10; i++) tick();
        check_val("t8_idle_no_slip", slips, 32'd0);
        check_val("t8_idle_unlocked", {31'd0, locked}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
